// File: rtl/axi4_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter; independent round-robin read and write FSMs, one outstanding per direction.
// Latency: request valid to out_*valid is one cycle (registered grant); data/response beats are pure muxes (0 cycles).
// Backpressure: owner ready follows the slave ready combinationally; the non-owner's ready is held at 0 until granted.
//
// Ports: clock_i / reset_i (async, active low), per-master in0_* / in1_* AXI4 slave ports
// (ar, r, aw, w, b) and a single downstream AXI4 master port out_*.
module axi4_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    // master 0 (instruction fetch)
    input  logic                in0_arvalid_i,
    output logic                in0_arready_o,
    input  logic [ID_W-1:0]     in0_arid_i,
    input  logic [ADDR_W-1:0]   in0_araddr_i,
    input  logic [7:0]          in0_arlen_i,
    input  logic [2:0]          in0_arsize_i,
    input  logic [1:0]          in0_arburst_i,
    output logic                in0_rvalid_o,
    input  logic                in0_rready_i,
    output logic [ID_W-1:0]     in0_rid_o,
    output logic [DATA_W-1:0]   in0_rdata_o,
    output logic [1:0]          in0_rresp_o,
    output logic                in0_rlast_o,
    input  logic                in0_awvalid_i,
    output logic                in0_awready_o,
    input  logic [ID_W-1:0]     in0_awid_i,
    input  logic [ADDR_W-1:0]   in0_awaddr_i,
    input  logic [7:0]          in0_awlen_i,
    input  logic [2:0]          in0_awsize_i,
    input  logic [1:0]          in0_awburst_i,
    input  logic                in0_wvalid_i,
    output logic                in0_wready_o,
    input  logic [DATA_W-1:0]   in0_wdata_i,
    input  logic [DATA_W/8-1:0] in0_wstrb_i,
    input  logic                in0_wlast_i,
    output logic                in0_bvalid_o,
    input  logic                in0_bready_i,
    output logic [ID_W-1:0]     in0_bid_o,
    output logic [1:0]          in0_bresp_o,
    // master 1 (load/store)
    input  logic                in1_arvalid_i,
    output logic                in1_arready_o,
    input  logic [ID_W-1:0]     in1_arid_i,
    input  logic [ADDR_W-1:0]   in1_araddr_i,
    input  logic [7:0]          in1_arlen_i,
    input  logic [2:0]          in1_arsize_i,
    input  logic [1:0]          in1_arburst_i,
    output logic                in1_rvalid_o,
    input  logic                in1_rready_i,
    output logic [ID_W-1:0]     in1_rid_o,
    output logic [DATA_W-1:0]   in1_rdata_o,
    output logic [1:0]          in1_rresp_o,
    output logic                in1_rlast_o,
    input  logic                in1_awvalid_i,
    output logic                in1_awready_o,
    input  logic [ID_W-1:0]     in1_awid_i,
    input  logic [ADDR_W-1:0]   in1_awaddr_i,
    input  logic [7:0]          in1_awlen_i,
    input  logic [2:0]          in1_awsize_i,
    input  logic [1:0]          in1_awburst_i,
    input  logic                in1_wvalid_i,
    output logic                in1_wready_o,
    input  logic [DATA_W-1:0]   in1_wdata_i,
    input  logic [DATA_W/8-1:0] in1_wstrb_i,
    input  logic                in1_wlast_i,
    output logic                in1_bvalid_o,
    input  logic                in1_bready_i,
    output logic [ID_W-1:0]     in1_bid_o,
    output logic [1:0]          in1_bresp_o,
    // downstream master port
    output logic                out_arvalid_o,
    input  logic                out_arready_i,
    output logic [ID_W-1:0]     out_arid_o,
    output logic [ADDR_W-1:0]   out_araddr_o,
    output logic [7:0]          out_arlen_o,
    output logic [2:0]          out_arsize_o,
    output logic [1:0]          out_arburst_o,
    input  logic                out_rvalid_i,
    output logic                out_rready_o,
    input  logic [ID_W-1:0]     out_rid_i,
    input  logic [DATA_W-1:0]   out_rdata_i,
    input  logic [1:0]          out_rresp_i,
    input  logic                out_rlast_i,
    output logic                out_awvalid_o,
    input  logic                out_awready_i,
    output logic [ID_W-1:0]     out_awid_o,
    output logic [ADDR_W-1:0]   out_awaddr_o,
    output logic [7:0]          out_awlen_o,
    output logic [2:0]          out_awsize_o,
    output logic [1:0]          out_awburst_o,
    output logic                out_wvalid_o,
    input  logic                out_wready_i,
    output logic [DATA_W-1:0]   out_wdata_o,
    output logic [DATA_W/8-1:0] out_wstrb_o,
    output logic                out_wlast_o,
    input  logic                out_bvalid_i,
    output logic                out_bready_o,
    input  logic [ID_W-1:0]     out_bid_i,
    input  logic [1:0]          out_bresp_i
);

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    logic      rd_owner_q, rd_owner_d;     // 0 = in0, 1 = in1
    logic      wr_owner_q, wr_owner_d;
    logic      rr_last_rd_q, rr_last_rd_d; // last granted master
    logic      rr_last_wr_q, rr_last_wr_d;
    logic      rd_win, wr_win;

    // On a tie the master that was not granted last wins; otherwise the sole requester.
    assign rd_win = (in0_arvalid_i && in1_arvalid_i) ? ~rr_last_rd_q : in1_arvalid_i;
    assign wr_win = (in0_awvalid_i && in1_awvalid_i) ? ~rr_last_wr_q : in1_awvalid_i;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_state_q   <= RD_IDLE;
            wr_state_q   <= WR_IDLE;
            rd_owner_q   <= 1'b0;
            wr_owner_q   <= 1'b0;
            rr_last_rd_q <= 1'b1;  // makes in0 win the first tie
            rr_last_wr_q <= 1'b1;
        end else begin
            rd_state_q   <= rd_state_d;
            wr_state_q   <= wr_state_d;
            rd_owner_q   <= rd_owner_d;
            wr_owner_q   <= wr_owner_d;
            rr_last_rd_q <= rr_last_rd_d;
            rr_last_wr_q <= rr_last_wr_d;
        end
    end

    // Read FSM: valids/readies are all gated by state, so reset forces them low at once.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_owner_d    = rd_owner_q;
        rr_last_rd_d  = rr_last_rd_q;
        out_arvalid_o = 1'b0;
        in0_arready_o = 1'b0;
        in1_arready_o = 1'b0;
        out_rready_o  = 1'b0;
        in0_rvalid_o  = 1'b0;
        in1_rvalid_o  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (in0_arvalid_i || in1_arvalid_i) begin
                    rd_owner_d   = rd_win;
                    rr_last_rd_d = rd_win;
                    rd_state_d   = RD_ADDR;
                end
            end
            RD_ADDR: begin
                out_arvalid_o = 1'b1;
                in0_arready_o = ~rd_owner_q & out_arready_i;
                in1_arready_o =  rd_owner_q & out_arready_i;
                if (out_arready_i) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                out_rready_o = rd_owner_q ? in1_rready_i : in0_rready_i;
                in0_rvalid_o = ~rd_owner_q & out_rvalid_i;
                in1_rvalid_o =  rd_owner_q & out_rvalid_i;
                // Slave's rlast ends the burst regardless of the requested len.
                if (out_rvalid_i && out_rready_o && out_rlast_i) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write FSM: W is only forwarded after the AW handshake.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_owner_d    = wr_owner_q;
        rr_last_wr_d  = rr_last_wr_q;
        out_awvalid_o = 1'b0;
        in0_awready_o = 1'b0;
        in1_awready_o = 1'b0;
        out_wvalid_o  = 1'b0;
        in0_wready_o  = 1'b0;
        in1_wready_o  = 1'b0;
        out_bready_o  = 1'b0;
        in0_bvalid_o  = 1'b0;
        in1_bvalid_o  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (in0_awvalid_i || in1_awvalid_i) begin
                    wr_owner_d   = wr_win;
                    rr_last_wr_d = wr_win;
                    wr_state_d   = WR_ADDR;
                end
            end
            WR_ADDR: begin
                out_awvalid_o = 1'b1;
                in0_awready_o = ~wr_owner_q & out_awready_i;
                in1_awready_o =  wr_owner_q & out_awready_i;
                if (out_awready_i) wr_state_d = WR_DATA;
            end
            WR_DATA: begin
                out_wvalid_o = wr_owner_q ? in1_wvalid_i : in0_wvalid_i;
                in0_wready_o = ~wr_owner_q & out_wready_i;
                in1_wready_o =  wr_owner_q & out_wready_i;
                if (out_wvalid_o && out_wready_i && out_wlast_o) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                out_bready_o = wr_owner_q ? in1_bready_i : in0_bready_i;
                in0_bvalid_o = ~wr_owner_q & out_bvalid_i;
                in1_bvalid_o =  wr_owner_q & out_bvalid_i;
                if (out_bvalid_i && out_bready_o) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Payload muxes: request side selected by owner, return side broadcast (valid is gated).
    assign out_arid_o    = rd_owner_q ? in1_arid_i    : in0_arid_i;
    assign out_araddr_o  = rd_owner_q ? in1_araddr_i  : in0_araddr_i;
    assign out_arlen_o   = rd_owner_q ? in1_arlen_i   : in0_arlen_i;
    assign out_arsize_o  = rd_owner_q ? in1_arsize_i  : in0_arsize_i;
    assign out_arburst_o = rd_owner_q ? in1_arburst_i : in0_arburst_i;
    assign out_awid_o    = wr_owner_q ? in1_awid_i    : in0_awid_i;
    assign out_awaddr_o  = wr_owner_q ? in1_awaddr_i  : in0_awaddr_i;
    assign out_awlen_o   = wr_owner_q ? in1_awlen_i   : in0_awlen_i;
    assign out_awsize_o  = wr_owner_q ? in1_awsize_i  : in0_awsize_i;
    assign out_awburst_o = wr_owner_q ? in1_awburst_i : in0_awburst_i;
    assign out_wdata_o   = wr_owner_q ? in1_wdata_i   : in0_wdata_i;
    assign out_wstrb_o   = wr_owner_q ? in1_wstrb_i   : in0_wstrb_i;
    assign out_wlast_o   = wr_owner_q ? in1_wlast_i   : in0_wlast_i;

    assign in0_rid_o   = out_rid_i;
    assign in0_rdata_o = out_rdata_i;
    assign in0_rresp_o = out_rresp_i;
    assign in0_rlast_o = out_rlast_i;
    assign in1_rid_o   = out_rid_i;
    assign in1_rdata_o = out_rdata_i;
    assign in1_rresp_o = out_rresp_i;
    assign in1_rlast_o = out_rlast_i;
    assign in0_bid_o   = out_bid_i;
    assign in0_bresp_o = out_bresp_i;
    assign in1_bid_o   = out_bid_i;
    assign in1_bresp_o = out_bresp_i;

endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
module tb_axi4_arbiter_2to1;
    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clock_i = ~clock_i;

    logic in0_arvalid_i, in0_arready_o, in0_rvalid_o, in0_rready_i, in0_rlast_o;
    logic in0_awvalid_i, in0_awready_o, in0_wvalid_i, in0_wready_o, in0_wlast_i, in0_bvalid_o, in0_bready_i;
    logic in1_arvalid_i, in1_arready_o, in1_rvalid_o, in1_rready_i, in1_rlast_o;
    logic in1_awvalid_i, in1_awready_o, in1_wvalid_i, in1_wready_o, in1_wlast_i, in1_bvalid_o, in1_bready_i;
    logic out_arvalid_o, out_arready_i, out_rvalid_i, out_rready_o, out_rlast_i;
    logic out_awvalid_o, out_awready_i, out_wvalid_o, out_wready_i, out_wlast_o, out_bvalid_i, out_bready_o;
    logic [3:0]  in0_arid_i, in0_rid_o, in0_awid_i, in0_bid_o, in1_arid_i, in1_rid_o, in1_awid_i, in1_bid_o;
    logic [3:0]  out_arid_o, out_rid_i, out_awid_o, out_bid_i;
    logic [31:0] in0_araddr_i, in0_rdata_o, in0_awaddr_i, in0_wdata_i;
    logic [31:0] in1_araddr_i, in1_rdata_o, in1_awaddr_i, in1_wdata_i;
    logic [31:0] out_araddr_o, out_rdata_i, out_awaddr_o, out_wdata_o;
    logic [7:0]  in0_arlen_i, in0_awlen_i, in1_arlen_i, in1_awlen_i, out_arlen_o, out_awlen_o;
    logic [2:0]  in0_arsize_i, in0_awsize_i, in1_arsize_i, in1_awsize_i, out_arsize_o, out_awsize_o;
    logic [1:0]  in0_arburst_i, in0_awburst_i, in1_arburst_i, in1_awburst_i, out_arburst_o, out_awburst_o;
    logic [1:0]  in0_rresp_o, in0_bresp_o, in1_rresp_o, in1_bresp_o, out_rresp_i, out_bresp_i;
    logic [3:0]  in0_wstrb_i, in1_wstrb_i, out_wstrb_o;

    axi4_arbiter_2to1 dut (
        .clock_i, .reset_i,
        .in0_arvalid_i, .in0_arready_o, .in0_arid_i, .in0_araddr_i, .in0_arlen_i, .in0_arsize_i, .in0_arburst_i,
        .in0_rvalid_o, .in0_rready_i, .in0_rid_o, .in0_rdata_o, .in0_rresp_o, .in0_rlast_o,
        .in0_awvalid_i, .in0_awready_o, .in0_awid_i, .in0_awaddr_i, .in0_awlen_i, .in0_awsize_i, .in0_awburst_i,
        .in0_wvalid_i, .in0_wready_o, .in0_wdata_i, .in0_wstrb_i, .in0_wlast_i,
        .in0_bvalid_o, .in0_bready_i, .in0_bid_o, .in0_bresp_o,
        .in1_arvalid_i, .in1_arready_o, .in1_arid_i, .in1_araddr_i, .in1_arlen_i, .in1_arsize_i, .in1_arburst_i,
        .in1_rvalid_o, .in1_rready_i, .in1_rid_o, .in1_rdata_o, .in1_rresp_o, .in1_rlast_o,
        .in1_awvalid_i, .in1_awready_o, .in1_awid_i, .in1_awaddr_i, .in1_awlen_i, .in1_awsize_i, .in1_awburst_i,
        .in1_wvalid_i, .in1_wready_o, .in1_wdata_i, .in1_wstrb_i, .in1_wlast_i,
        .in1_bvalid_o, .in1_bready_i, .in1_bid_o, .in1_bresp_o,
        .out_arvalid_o, .out_arready_i, .out_arid_o, .out_araddr_o, .out_arlen_o, .out_arsize_o, .out_arburst_o,
        .out_rvalid_i, .out_rready_o, .out_rid_i, .out_rdata_i, .out_rresp_i, .out_rlast_i,
        .out_awvalid_o, .out_awready_i, .out_awid_o, .out_awaddr_o, .out_awlen_o, .out_awsize_o, .out_awburst_o,
        .out_wvalid_o, .out_wready_i, .out_wdata_o, .out_wstrb_o, .out_wlast_o,
        .out_bvalid_i, .out_bready_o, .out_bid_i, .out_bresp_i
    );

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];

    typedef struct { bit r0; bit r1; bit exp_m; } arb_vec_t;
    arb_vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic any_vr();
        return out_arvalid_o | out_rready_o | out_awvalid_o | out_wvalid_o | out_bready_o |
               in0_arready_o | in0_rvalid_o | in0_awready_o | in0_wready_o | in0_bvalid_o |
               in1_arready_o | in1_rvalid_o | in1_awready_o | in1_wready_o | in1_bvalid_o;
    endfunction

    // Issue one AR (single or tie) and complete its address handshake.
    task automatic do_ar(input bit r0, input bit r1, input bit exp_m,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [7:0] len);
        @(negedge clock_i);
        in0_arvalid_i = r0; in1_arvalid_i = r1;
        in0_araddr_i = a0; in1_araddr_i = a1;
        in0_arlen_i = len; in1_arlen_i = len;
        in0_arid_i = 4'h1; in1_arid_i = 4'h2;
        #1;
        chk("ar_no_comb_path", out_arvalid_o, 0);
        chk("ar_idle_ready", {in1_arready_o, in0_arready_o}, 0);
        @(negedge clock_i);
        out_arready_i = 1'b1;
        #1;
        chk("ar_valid", out_arvalid_o, 1);
        chk("ar_addr", out_araddr_o, exp_m ? a1 : a0);
        chk("ar_len", out_arlen_o, len);
        chk("ar_id", out_arid_o, exp_m ? 4'h2 : 4'h1);
        chk("ar_grant", {in1_arready_o, in0_arready_o}, exp_m ? 2'b10 : 2'b01);
        @(negedge clock_i);
        out_arready_i = 1'b0;
        in0_arvalid_i = 1'b0; in1_arvalid_i = 1'b0;
    endtask

    // Slave returns n beats to master m; beats are scoreboarded and popped on master-side handshakes.
    task automatic rd_data(input bit m, input int n, input bit tog, input logic [31:0] base);
        int sent = 0;
        int mhs = 0;
        int cyc = 0;
        bit pushed = 0;
        bit rdy;
        logic [31:0] e;
        while (sent < n && cyc < 100) begin
            @(negedge clock_i);
            cyc++;
            rdy = tog ? cyc[0] : 1'b1;
            if (m) begin in1_rready_i = rdy; in0_rready_i = 1'b1; end
            else   begin in0_rready_i = rdy; in1_rready_i = 1'b1; end
            out_rvalid_i = 1'b1;
            out_rdata_i  = base + sent;
            out_rlast_i  = (sent == n - 1);
            out_rid_i    = m ? 4'h2 : 4'h1;
            if (!pushed) begin rd_q.push_back(base + sent); pushed = 1; end
            #1;
            chk("r_nonowner_valid", m ? in0_rvalid_o : in1_rvalid_o, 0);
            chk("r_ready_route", out_rready_o, rdy);
            if (m ? (in1_rvalid_o && in1_rready_i) : (in0_rvalid_o && in0_rready_i)) begin
                e = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
                chk("r_data", m ? in1_rdata_o : in0_rdata_o, e);
                chk("r_last", m ? in1_rlast_o : in0_rlast_o, (mhs == n - 1));
                mhs++;
            end
            if (out_rready_o) begin sent++; pushed = 0; end
        end
        chk("r_master_beats", mhs, n);
        chk("r_slave_beats", sent, n);
        chk("r_sb_empty", rd_q.size(), 0);
        rd_q.delete();
        // Back in RD_IDLE: an unsolicited beat must be neither accepted nor forwarded.
        @(negedge clock_i);
        in0_rready_i = 1'b1; in1_rready_i = 1'b1;
        #1;
        chk("r_unsolicited_ready", out_rready_o, 0);
        chk("r_unsolicited_fwd", {in1_rvalid_o, in0_rvalid_o}, 0);
        out_rvalid_i = 1'b0; out_rlast_i = 1'b0;
    endtask

    initial begin #400000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        {in0_arvalid_i, in0_rready_i, in0_awvalid_i, in0_wvalid_i, in0_wlast_i, in0_bready_i} = '0;
        {in1_arvalid_i, in1_rready_i, in1_awvalid_i, in1_wvalid_i, in1_wlast_i, in1_bready_i} = '0;
        {out_arready_i, out_rvalid_i, out_rlast_i, out_awready_i, out_wready_i, out_bvalid_i} = '0;
        {in0_arid_i, in0_awid_i, in1_arid_i, in1_awid_i, out_rid_i, out_bid_i} = '0;
        {in0_araddr_i, in0_awaddr_i, in0_wdata_i, in1_araddr_i, in1_awaddr_i, in1_wdata_i, out_rdata_i} = '0;
        {in0_arlen_i, in0_awlen_i, in1_arlen_i, in1_awlen_i} = '0;
        {in0_arsize_i, in0_awsize_i, in1_arsize_i, in1_awsize_i} = '0;
        {in0_arburst_i, in0_awburst_i, in1_arburst_i, in1_awburst_i, out_rresp_i, out_bresp_i} = '0;
        {in0_wstrb_i, in1_wstrb_i} = '0;

        tbl[0] = '{1, 1, 0}; tbl[1] = '{1, 1, 1}; tbl[2] = '{1, 1, 0};
        tbl[3] = '{1, 1, 1}; tbl[4] = '{0, 1, 1}; tbl[5] = '{1, 0, 0};

        // Reset: requests present, still no valid/ready may be asserted.
        in0_arvalid_i = 1'b1; in1_awvalid_i = 1'b1; out_rvalid_i = 1'b1; out_bvalid_i = 1'b1;
        in0_rready_i = 1'b1; in1_bready_i = 1'b1; out_arready_i = 1'b1; out_wready_i = 1'b1;
        repeat (2) @(negedge clock_i);
        #1 chk("reset_outputs", any_vr(), 0);
        @(negedge clock_i);
        {in0_arvalid_i, in1_awvalid_i, out_rvalid_i, out_bvalid_i} = '0;
        {in0_rready_i, in1_bready_i, out_arready_i, out_wready_i} = '0;
        reset_i = 1'b1;

        // Single 4-beat read by in0.
        do_ar(1, 0, 0, 32'h3000_0000, 32'h0, 8'd3);
        rd_data(0, 4, 0, 32'hC0DE_0000);

        // Write burst by in1: W presented early must not leak before the AW handshake.
        @(negedge clock_i);
        in1_awvalid_i = 1'b1; in1_awaddr_i = 32'h8000_0100; in1_awlen_i = 8'd1; in1_awid_i = 4'h2;
        in1_wvalid_i = 1'b1; in1_wdata_i = 32'hDEAD_BEEF; in1_wstrb_i = 4'hF; in1_wlast_i = 1'b0;
        out_wready_i = 1'b1; in0_bready_i = 1'b1;
        #1;
        chk("w_blocked_idle", {out_awvalid_o, out_wvalid_o, in1_wready_o}, 0);
        @(negedge clock_i);
        out_awready_i = 1'b1;
        #1;
        chk("aw_valid", out_awvalid_o, 1);
        chk("aw_addr", out_awaddr_o, 32'h8000_0100);
        chk("aw_len", out_awlen_o, 1);
        chk("aw_grant", {in1_awready_o, in0_awready_o}, 2'b10);
        chk("w_blocked_addr", {out_wvalid_o, in1_wready_o}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_i);
            in1_awvalid_i = 1'b0; out_awready_i = 1'b0;
            in1_wdata_i = (i == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            in1_wlast_i = (i == 1);
            wr_q.push_back(in1_wdata_i);
            #1;
            chk("w_valid", out_wvalid_o, 1);
            chk("w_ready_route", in1_wready_o, 1);
            if (out_wvalid_o && out_wready_i && wr_q.size() != 0) chk("w_data", out_wdata_o, wr_q.pop_front());
            chk("w_strb", out_wstrb_o, 4'hF);
            chk("w_last", out_wlast_o, (i == 1));
        end
        chk("w_sb_empty", wr_q.size(), 0);
        wr_q.delete();
        @(negedge clock_i);
        in1_wvalid_i = 1'b0; in1_wlast_i = 1'b0; out_wready_i = 1'b0;
        out_bvalid_i = 1'b1; out_bresp_i = 2'b00; out_bid_i = 4'h2; in1_bready_i = 1'b1;
        #1;
        chk("b_valid_owner", in1_bvalid_o, 1);
        chk("b_resp", in1_bresp_o, 0);
        chk("b_id", in1_bid_o, 4'h2);
        chk("b_nonowner", in0_bvalid_o, 0);
        chk("b_ready", out_bready_o, 1);
        @(negedge clock_i);
        #1;
        chk("b_unsolicited", {out_bready_o, in1_bvalid_o, in0_bvalid_o}, 0);
        out_bvalid_i = 1'b0;

        // Fresh reset so rr pointers start from their reset value, then the arbitration table.
        @(negedge clock_i); reset_i = 1'b0;
        @(negedge clock_i); reset_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_ar(tbl[i].r0, tbl[i].r1, tbl[i].exp_m, 32'h1000_0000 + i * 256, 32'h2000_0000 + i * 256, 8'd0);
            rd_data(tbl[i].exp_m, 1, 0, 32'h5000_0000 + i * 16);
        end

        // Concurrent read (in0) and write (in1).
        @(negedge clock_i);
        in0_arvalid_i = 1'b1; in0_araddr_i = 32'h4000_0000; in0_arlen_i = 8'd0;
        in1_awvalid_i = 1'b1; in1_awaddr_i = 32'h9000_0000; in1_awlen_i = 8'd0;
        @(negedge clock_i);
        out_arready_i = 1'b1; out_awready_i = 1'b1;
        #1;
        chk("conc_same_cycle", {out_arvalid_o, out_awvalid_o}, 2'b11);
        chk("conc_grants", {in0_arready_o, in1_awready_o}, 2'b11);
        @(negedge clock_i);
        {in0_arvalid_i, in1_awvalid_i, out_arready_i, out_awready_i} = '0;
        out_rvalid_i = 1'b1; out_rdata_i = 32'hAAAA_5555; out_rlast_i = 1'b1; in0_rready_i = 1'b1;
        in1_wvalid_i = 1'b1; in1_wdata_i = 32'h0BAD_F00D; in1_wlast_i = 1'b1; out_wready_i = 1'b1;
        #1;
        chk("conc_r", {in0_rvalid_o, out_rready_o}, 2'b11);
        chk("conc_rdata", in0_rdata_o, 32'hAAAA_5555);
        chk("conc_w", {out_wvalid_o, in1_wready_o}, 2'b11);
        chk("conc_wdata", out_wdata_o, 32'h0BAD_F00D);
        @(negedge clock_i);
        {out_rvalid_i, out_rlast_i, in1_wvalid_i, in1_wlast_i, out_wready_i} = '0;
        out_bvalid_i = 1'b1; out_bresp_i = 2'b10; in1_bready_i = 1'b1;
        #1;
        chk("conc_b", {in1_bvalid_o, out_bready_o, in0_bvalid_o}, 3'b110);
        chk("conc_bresp", in1_bresp_o, 2'b10);
        chk("conc_r_idle", out_rready_o, 0);
        @(negedge clock_i);
        out_bvalid_i = 1'b0;

        // Backpressure: 8-beat read with in0 rready alternating.
        do_ar(1, 0, 0, 32'h3100_0000, 32'h0, 8'd7);
        rd_data(0, 8, 1, 32'h0000_0100);

        // Reset during beat 2 of a 4-beat read.
        do_ar(1, 0, 0, 32'h3200_0000, 32'h0, 8'd3);
        for (int b = 0; b < 3; b++) begin
            @(negedge clock_i);
            out_rvalid_i = 1'b1; out_rdata_i = b; out_rlast_i = 1'b0; in0_rready_i = 1'b1;
        end
        #1 chk("rst_pre_ready", out_rready_o, 1);
        reset_i = 1'b0;
        #1 chk("rst_async_drop", any_vr(), 0);
        @(negedge clock_i);
        out_rvalid_i = 1'b0;
        reset_i = 1'b1;
        do_ar(1, 1, 0, 32'h3300_0000, 32'h3400_0000, 8'd0);
        rd_data(0, 1, 0, 32'h7700_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
